multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1; 1 = memory states hold until mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction [31:26] from the instruction register; sampled only in DECODE.
REQ-005 mem_ready  input  1  memory access completes in the current cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 PCSource, ALUOp, ALUSrcB  output  2 each  mux selects and ALU-op class.
REQ-008 illegal_op  output  1  one-cycle pulse: unsupported opcode decoded.
REQ-009 state  output  4  current state encoding, for debug.

Function
REQ-010 Moore FSM; all control outputs are decoded from the state register only; illegal_op is registered.
REQ-011 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9.
REQ-012 Outputs not listed for a state are 0; no X is ever driven.
REQ-013 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, PCSource=00, IorD=0, ALUOp=00.
REQ-014 FETCH: IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; the state then goes to DECODE, otherwise it holds in FETCH.
REQ-015 DECODE: ALUSrcB=11, ALUOp=00; next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP.
REQ-016 DECODE with any other opcode: next state is FETCH and illegal_op=1 for exactly the following cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for lw and MEMWR for sw.
REQ-018 The opcode class decoded in DECODE is latched internally; opcode changes after DECODE have no effect.
REQ-019 MEMRD: MemRead=1, IorD=1; holds until mem_ready, then goes to MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state is FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; holds until mem_ready, then goes to FETCH.
REQ-022 MemWrite is held asserted for every cycle spent in MEMWR.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state is ALUWB.
REQ-024 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next state is FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state is FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10; next state is FETCH.
REQ-027 Cycle counts with mem_ready held 1: beq=3, j=3, R-type=4, sw=4, lw=5.
REQ-028 Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-029 Unused encodings 10-15: all outputs 0; next state is FETCH.
REQ-030 At most one of MemRead or MemWrite is 1 in any cycle.
REQ-031 RegWrite and PCWrite are never both 1 in any cycle.

Reset
REQ-032 A rising edge with rst=1 sets state=FETCH and illegal_op=0, and clears the latched opcode class.
REQ-033 While rst=1, all control outputs are forced to 0 combinationally, overriding the state decode.
REQ-034 Reset has priority over every transition, including a memory stall and the middle of an instruction.
REQ-035 After rst deasserts, the first cycle is FETCH with its normal outputs.

Verification
REQ-036 lw, mem_ready=1: states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-037 R-type opcode 000000: states 0,1,6,7,0; ALUOp=10 in EXEC; RegDst=1 and RegWrite=1 in ALUWB.
REQ-038 sw with mem_ready low for 2 cycles in MEMWR: state 5 held for 3 cycles with MemWrite=1 throughout, then FETCH.
REQ-039 beq then j back-to-back: states 0,1,8,0,1,9,0; PCWriteCond=1 only in state 8; PCSource=10 in state 9.
REQ-040 Opcode 001000 in DECODE: next state FETCH; illegal_op=1 for one cycle; no RegWrite or MemWrite at any point.
REQ-041 rst pulsed while in MEMRD: all outputs are 0 during the pulse; state=0 on the next edge; lw is not completed.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: state-decoded datapath controls, registered illegal_op pulse.
// Memory states stall until mem_ready (unless MEM_WAIT_EN=0); rst forces every control output low.
module multicycle_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LW   = 2'd1,
        CLS_SW   = 2'd2
    } cls_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;
    cls_t   cls;
    logic   illegal_q;
    logic   ready;

    assign ready = mem_ready | ~MEM_WAIT_EN;

    // The load/store class is captured in DECODE so MEMADR never looks at opcode again.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= FETCH;
            cls       <= CLS_NONE;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (cur)
                FETCH:  if (ready) cur <= DECODE;
                DECODE: begin
                    cls <= CLS_NONE;
                    case (opcode)
                        OP_LW:    begin cls <= CLS_LW; cur <= MEMADR; end
                        OP_SW:    begin cls <= CLS_SW; cur <= MEMADR; end
                        OP_RTYPE: cur <= EXEC;
                        OP_BEQ:   cur <= BRANCH;
                        OP_J:     cur <= JUMP;
                        default:  begin cur <= FETCH; illegal_q <= 1'b1; end
                    endcase
                end
                MEMADR: begin
                    if (cls == CLS_SW)      cur <= MEMWR;
                    else if (cls == CLS_LW) cur <= MEMRD;
                    else                    cur <= FETCH;
                end
                MEMRD:  if (ready) cur <= MEMWB;
                MEMWR:  if (ready) cur <= FETCH;
                EXEC:   cur <= ALUWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        if (!rst) begin
            case (cur)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = ready;
                    PCWrite = ready;
                end
                DECODE: ALUSrcB = 2'b11;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign illegal_op = illegal_q & ~rst;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction scenarios plus randomized instruction streams
// with random memory stalls, checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
        logic [1:0] pcsrc, aluop, srcb;
    } ctrl_t;

    logic       clk, rst, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;

    logic       pcw2, pcwc2, iord2, mrd2, mwr2, m2r2, irw2, srca2, rw2, rdst2, ill2;
    logic [1:0] pcsrc2, aluop2, srcb2;
    logic [3:0] state2;

    int    n_pass = 0;
    int    n_total = 0;
    bit    pend_ill = 1'b0;
    ctrl_t obs;

    assign obs = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .illegal_op(illegal_op), .state(state)
    );

    multicycle_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(1'b0),
        .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mrd2),
        .MemWrite(mwr2), .MemtoReg(m2r2), .IRWrite(irw2), .ALUSrcA(srca2),
        .RegWrite(rw2), .RegDst(rdst2), .PCSource(pcsrc2), .ALUOp(aluop2),
        .ALUSrcB(srcb2), .illegal_op(ill2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] rnd6();
        logic [5:0] v;
        v = 6'($urandom);
        return v;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) || (op == OP_J);
    endfunction

    // Control table per state; r is the memory-ready condition seen in that cycle.
    function automatic ctrl_t exp_ctrl(input int s, input bit r);
        ctrl_t c;
        c = '0;
        case (s)
            0: begin c.mrd = 1; c.srcb = 2'b01; c.irw = r; c.pcw = r; end
            1: c.srcb = 2'b11;
            2: begin c.srca = 1; c.srcb = 2'b10; end
            3: begin c.mrd = 1; c.iord = 1; end
            4: begin c.rw = 1; c.m2r = 1; end
            5: begin c.mwr = 1; c.iord = 1; end
            6: begin c.srca = 1; c.aluop = 2'b10; end
            7: begin c.rw = 1; c.rdst = 1; end
            8: begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            9: begin c.pcw = 1; c.pcsrc = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock: drive inputs, check at the falling edge, then advance past the rising edge.
    task automatic cycle(input int es, input bit r, input logic [5:0] op, input bit eill);
        mem_ready = r;
        opcode    = op;
        @(negedge clk);
        chk($sformatf("state(exp %0d)", es), 32'(state), 32'(es));
        chk($sformatf("ctrl(st %0d)", es), 32'(obs), 32'(exp_ctrl(es, r)));
        chk($sformatf("illegal(st %0d)", es), 32'(illegal_op), 32'(eill));
        chk("mem_rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
        chk("regw_pcw_excl", 32'(RegWrite & PCWrite), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        opcode    = rnd6();
        @(negedge clk);
        chk("rst_ctrl_zero", 32'(obs), 32'd0);
        chk("rst_illegal_zero", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pend_ill = 1'b0;
    endtask

    task automatic mem_wait(input int s, input int stall);
        for (int i = 0; i < stall; i++) cycle(s, 1'b0, rnd6(), 1'b0);
        cycle(s, 1'b1, rnd6(), 1'b0);
    endtask

    // Instruction-level model: expected state walk follows from the opcode and the stall counts.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        for (int i = 0; i < fstall; i++) begin
            cycle(0, 1'b0, rnd6(), pend_ill);
            pend_ill = 1'b0;
        end
        cycle(0, 1'b1, rnd6(), pend_ill);
        pend_ill = 1'b0;
        cycle(1, 1'($urandom), op, 1'b0);
        if (op == OP_LW) begin
            cycle(2, 1'($urandom), rnd6(), 1'b0);
            mem_wait(3, mstall);
            cycle(4, 1'($urandom), rnd6(), 1'b0);
        end else if (op == OP_SW) begin
            cycle(2, 1'($urandom), rnd6(), 1'b0);
            mem_wait(5, mstall);
        end else if (op == OP_R) begin
            cycle(6, 1'($urandom), rnd6(), 1'b0);
            cycle(7, 1'($urandom), rnd6(), 1'b0);
        end else if (op == OP_BEQ) begin
            cycle(8, 1'($urandom), rnd6(), 1'b0);
        end else if (op == OP_J) begin
            cycle(9, 1'($urandom), rnd6(), 1'b0);
        end else begin
            pend_ill = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] op;
        clk       = 1'b0;
        rst       = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_cycle();

        // Fetch stall on the waiting instance; the no-wait instance ignores mem_ready.
        mem_ready = 1'b0;
        opcode    = OP_R;
        @(negedge clk);
        chk("fetch_stall_state", 32'(state), 32'd0);
        chk("fetch_stall_irw", 32'(IRWrite), 32'd0);
        chk("fetch_stall_pcw", 32'(PCWrite), 32'd0);
        chk("nowait_irw", 32'(irw2), 32'd1);
        chk("nowait_pcw", 32'(pcw2), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fetch_stall_state2", 32'(state), 32'd0);
        chk("nowait_decode", 32'(state2), 32'd1);
        @(posedge clk);
        #1;
        rst_cycle();

        run_instr(OP_LW, 0, 0);
        run_instr(OP_R, 0, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(OP_LW, 1, 1);

        // Reset in the middle of a stalled lw: the load must not complete.
        cycle(0, 1'b1, rnd6(), 1'b0);
        cycle(1, 1'b1, OP_LW, 1'b0);
        cycle(2, 1'b1, rnd6(), 1'b0);
        cycle(3, 1'b0, rnd6(), 1'b0);
        rst_cycle();
        run_instr(OP_SW, 0, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: begin
                    op = rnd6();
                    while (is_legal(op)) op = rnd6();
                end
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) rst_cycle();
        end
        run_instr(OP_R, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
